// File: rtl/sc_hdlc_stuff_tx_pkg.sv
// Shared constants and types for the HDLC slow-control serializer.
// Frame patterns and state encodings are also used by the receive deframer.
package sc_hdlc_stuff_tx_pkg;

  localparam logic [7:0] FLAG      = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'hFF;
  localparam logic [2:0] STUFF_RUN = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_CLOSE = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_byte_t;

  // Bit idx of a fixed pattern, LSB first on the wire.
  function automatic logic pat_bit(input logic [7:0] pat, input logic [2:0] idx);
    return pat[idx];
  endfunction

endpackage

// File: rtl/sc_hdlc_stuff_tx_bit_stuffer.sv
// Ones counter for HDLC zero insertion: flags a stuffed 0 after STUFF_RUN data 1s
// and asks the shifter to hold its data bit for that bit time.
module sc_bit_stuffer
  import sc_hdlc_stuff_tx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic active,
  input  logic bit_in,
  input  logic clr,
  output logic stuff_now,
  output logic will_stuff
);

  logic [2:0] ones_q, ones_d;
  logic       pend_q, pend_d;

  // Hold request now, and a look-ahead that the bit going out completes a run.
  always_comb begin
    stuff_now  = active & pend_q;
    will_stuff = active & ~pend_q & bit_in & (ones_q == (STUFF_RUN - 3'd1));
  end

  // Ones count and stuff-pending update, one step per bit time.
  always_comb begin
    ones_d = ones_q;
    pend_d = pend_q;
    if (ce) begin
      if (clr) begin
        ones_d = 3'd0;
        pend_d = 1'b0;
      end else if (active) begin
        if (pend_q) begin
          ones_d = 3'd0;
          pend_d = 1'b0;
        end else if (bit_in) begin
          if (ones_q == (STUFF_RUN - 3'd1)) begin
            ones_d = STUFF_RUN;
            pend_d = 1'b1;
          end else begin
            ones_d = ones_q + 3'd1;
            pend_d = 1'b0;
          end
        end else begin
          ones_d = 3'd0;
          pend_d = 1'b0;
        end
      end else begin
        ones_d = ones_q;
        pend_d = pend_q;
      end
    end else begin
      ones_d = ones_q;
      pend_d = pend_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ones_q <= 3'd0;
      pend_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/sc_hdlc_stuff_tx.sv
// HDLC slow-control transmitter: one-byte holding buffer, LSB-first shifter
// and frame FSM (idle flags, data with zero stuffing, closing flag, abort).
module sc_hdlc_stuff_tx
  import sc_hdlc_stuff_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dout,
  output logic       busy,
  output logic       frame_done,
  output logic       abort_pulse
);

  logic [1:0] state_q, state_d, nxt_state_s;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       cur_last_q, cur_last_d;
  tx_byte_t   buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic       tail_q, tail_d;
  logic       dout_q, dout_d;
  logic       busy_q, busy_d;
  logic       tx_ready_q, tx_ready_d;
  logic       frame_done_q, frame_done_d;
  logic       abort_pulse_q, abort_pulse_d;

  logic accept_s, boundary_s, nxt_load_s, load_s, clr_s, tx_bit_s;
  logic active_s, stuff_now_s, will_stuff_s;

  sc_bit_stuffer u_stuffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .active     (active_s),
    .bit_in     (shreg_q[0]),
    .clr        (clr_s),
    .stuff_now  (stuff_now_s),
    .will_stuff (will_stuff_s)
  );

  // A run completed by bit 7 defers the boundary to the stuffed-0 bit time (tail).
  always_comb begin
    active_s = (state_q == ST_DATA);
    accept_s = tx_valid & ~buf_full_q;
    if (ce) begin
      if (stuff_now_s) begin
        boundary_s = tail_q;
      end else begin
        boundary_s = (bit_idx_q == 3'd7) & ~will_stuff_s;
      end
    end else begin
      boundary_s = 1'b0;
    end
  end

  // Frame FSM: decisions taken only at byte boundaries.
  always_comb begin
    nxt_state_s = ST_IDLE;
    nxt_load_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_CLOSE: begin
        if (buf_full_q) begin
          nxt_state_s = ST_DATA;
          nxt_load_s  = 1'b1;
        end else begin
          nxt_state_s = ST_IDLE;
          nxt_load_s  = 1'b0;
        end
      end
      ST_DATA: begin
        if (cur_last_q) begin
          nxt_state_s = ST_CLOSE;
          nxt_load_s  = 1'b0;
        end else if (buf_full_q) begin
          nxt_state_s = ST_DATA;
          nxt_load_s  = 1'b1;
        end else begin
          nxt_state_s = ST_ABORT;
          nxt_load_s  = 1'b0;
        end
      end
      ST_ABORT: begin
        nxt_state_s = ST_IDLE;
        nxt_load_s  = 1'b0;
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_load_s  = 1'b0;
      end
    endcase
    load_s  = boundary_s & nxt_load_s;
    clr_s   = boundary_s & (nxt_state_s != ST_DATA);
    state_d = boundary_s ? nxt_state_s : state_q;
  end

  // Bit selection for the current bit time.
  always_comb begin
    case (state_q)
      ST_IDLE, ST_CLOSE: tx_bit_s = pat_bit(FLAG, bit_idx_q);
      ST_DATA:           tx_bit_s = stuff_now_s ? 1'b0 : shreg_q[0];
      ST_ABORT:          tx_bit_s = pat_bit(ABORT_PAT, bit_idx_q);
      default:           tx_bit_s = 1'b1;
    endcase
  end

  // Bit index, shifter, holding buffer and output next-state.
  always_comb begin
    bit_idx_d = bit_idx_q;
    tail_d    = tail_q;
    if (!ce) begin
      bit_idx_d = bit_idx_q;
      tail_d    = tail_q;
    end else if (stuff_now_s) begin
      bit_idx_d = tail_q ? 3'd0 : bit_idx_q;
      tail_d    = 1'b0;
    end else if (will_stuff_s && (bit_idx_q == 3'd7)) begin
      bit_idx_d = bit_idx_q;
      tail_d    = 1'b1;
    end else begin
      bit_idx_d = bit_idx_q + 3'd1;
      tail_d    = 1'b0;
    end

    if (load_s) begin
      shreg_d    = buf_q.data;
      cur_last_d = buf_q.last;
    end else if (ce && active_s && !stuff_now_s) begin
      shreg_d    = {1'b0, shreg_q[7:1]};
      cur_last_d = cur_last_q;
    end else begin
      shreg_d    = shreg_q;
      cur_last_d = cur_last_q;
    end

    if (accept_s) begin
      buf_d = '{data: tx_data, last: tx_last};
    end else begin
      buf_d = buf_q;
    end
    buf_full_d = load_s ? accept_s : (buf_full_q | accept_s);

    dout_d        = ce ? tx_bit_s : dout_q;
    busy_d        = (state_d != ST_IDLE);
    tx_ready_d    = ~buf_full_d;
    frame_done_d  = ce & (state_q == ST_CLOSE) & (bit_idx_q == 3'd7);
    abort_pulse_d = ce & (state_q == ST_ABORT) & (bit_idx_q == 3'd0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= 3'd0;
      shreg_q       <= 8'd0;
      cur_last_q    <= 1'b0;
      buf_q         <= '{data: 8'd0, last: 1'b0};
      buf_full_q    <= 1'b0;
      tail_q        <= 1'b0;
      dout_q        <= 1'b1;
      busy_q        <= 1'b0;
      tx_ready_q    <= 1'b1;
      frame_done_q  <= 1'b0;
      abort_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      cur_last_q    <= cur_last_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      tail_q        <= tail_d;
      dout_q        <= dout_d;
      busy_q        <= busy_d;
      tx_ready_q    <= tx_ready_d;
      frame_done_q  <= frame_done_d;
      abort_pulse_q <= abort_pulse_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign dout        = dout_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign abort_pulse = abort_pulse_q;

endmodule

// File: tb/tb_sc_hdlc_stuff_tx.sv
// Scoreboard bench for sc_hdlc_stuff_tx: expected wire bits are queued with the
// stimulus and a monitor pops one per bit time once the frame starts.
module tb_sc_hdlc_stuff_tx;

  typedef struct packed {
    logic d;
    logic fd;
    logic ap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, dout, busy, frame_done, abort_pulse;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  int   arm_req = 0;
  logic ce_en = 1'b0;
  int   ce_div = 1;

  sc_hdlc_stuff_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .dout        (dout),
    .busy        (busy),
    .frame_done  (frame_done),
    .abort_pulse (abort_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Bit-time enable generator.
  initial begin
    int cnt = 0;
    ce = 1'b0;
    forever begin
      @(negedge clk);
      cnt++;
      ce = ce_en && ((cnt % ce_div) == 0);
    end
  end

  // Monitor: arms on request or on busy rising, then compares one bit per ce.
  initial begin
    logic busy_prev = 1'b0;
    logic started = 1'b0;
    logic ce_s, rst_s;
    int   arm_seen = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      ce_s  = ce;
      rst_s = rst_n;
      @(negedge clk);
      if (arm_req != arm_seen) begin
        arm_seen = arm_req;
        started  = 1'b1;
      end
      if (ce_s && rst_s) begin
        if (started && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wire_bit{dout,fd,ap}", {29'd0, dout, frame_done, abort_pulse},
                {29'd0, e.d, e.fd, e.ap});
          if (exp_q.size() == 0) started = 1'b0;
        end else if (!busy_prev && busy && exp_q.size() > 0) begin
          started = 1'b1;
        end
      end
      busy_prev = busy;
    end
  end

  task automatic push_seq(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back('{d: v[i], fd: 1'b0, ap: 1'b0});
  endtask

  task automatic push_flag(input logic with_fd);
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) exp_q.push_back('{d: f[i], fd: with_fd && (i == 7), ap: 1'b0});
  endtask

  task automatic push_abort();
    for (int i = 0; i < 8; i++) exp_q.push_back('{d: 1'b1, fd: 1'b0, ap: (i == 0)});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_timeout", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_drop", {31'd0, tx_ready}, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saved;
    int   changed;
    int   n;

    // Reset values.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_dout", {31'd0, dout}, 32'd1);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_abort_pulse", {31'd0, abort_pulse}, 32'd0);

    // Idle flags with ce every 4th clock.
    @(posedge clk); #2;
    ce_div = 4;
    push_flag(1'b0);
    push_flag(1'b0);
    arm_req++;
    ce_en = 1'b1;
    drain();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_tx_ready", {31'd0, tx_ready}, 32'd1);

    @(posedge clk); #2;
    ce_div = 1;

    // 0x1F single-byte frame: stuff after five 1s, then closing and idle flags.
    push_seq(64'b111110000, 9);
    push_flag(1'b1);
    push_flag(1'b0);
    send_byte(8'h1F, 1'b1);
    drain();

    // 0xFF,0xFF: stuffing every five ones across the byte boundary.
    push_seq(64'b1111101111101111101, 19);
    push_flag(1'b1);
    push_flag(1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b1);
    drain();

    // 0xF0,0x03: run of 4 carried into byte 2, stuff after its first 1.
    push_seq(64'b00001111101000000, 17);
    push_flag(1'b1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h03, 1'b1);
    drain();

    // 0xF8: run completed by bit 7, stuffed 0 goes before the closing flag.
    push_seq(64'b000111110, 9);
    push_flag(1'b1);
    push_flag(1'b0);
    send_byte(8'hF8, 1'b1);
    drain();

    // Underrun: 0x55 not last, then abort, then idle flags.
    push_seq(64'b10101010, 8);
    push_abort();
    push_flag(1'b0);
    send_byte(8'h55, 1'b0);
    drain();
    check("abort_busy", {31'd0, busy}, 32'd0);

    // A later byte opens a new frame.
    push_seq(64'b10000001, 8);
    push_flag(1'b1);
    send_byte(8'h81, 1'b1);
    drain();

    // ce held low mid-byte, then reset mid-frame.
    send_byte(8'h1F, 1'b1);
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_busy_rise", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    ce_en = 1'b0;
    @(negedge clk);
    saved = dout;
    changed = 0;
    repeat (100) begin
      @(negedge clk);
      if (dout !== saved || busy !== 1'b1) changed++;
    end
    check("ce_hold_stable", changed, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_dout", {31'd0, dout}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    @(posedge clk); #2;
    push_flag(1'b0);
    push_flag(1'b0);
    arm_req++;
    ce_en = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
